// File: rtl/hazard_control_unit.sv
// Stall/flush sequencer for the 5-stage core with branch resolution in ID.
// Detects load hazards that forwarding cannot cover, drives PC / IF/ID /
// ID/EX enables, and keeps saturating stall and flush counters.
module hazard_control_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  rs1_IFID,
   input  logic [4:0]  rs2_IFID,
   input  logic        uses_rs1_IFID,
   input  logic        uses_rs2_IFID,
   input  logic        IDControlBranch,
   input  logic        branch_taken,
   input  logic        jump_ID,
   input  logic [4:0]  Rd_IDEX,
   input  logic        MemRead_IDEX,
   input  logic [4:0]  Rd_EXMEM,
   input  logic        MemRead_EXMEM,
   input  logic        dmem_busy,
   output logic        PCWrite,
   output logic        IFIDWrite,
   output logic        IDEX_bubble,
   output logic        IFID_flush,
   output logic        pipe_freeze,
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_count
);

   typedef enum logic {RUN, STALL} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [15:0] stall_q, stall_d;
   logic [15:0] flush_q, flush_d;
   logic        m_ex, m_mem;
   logic [1:0]  need;

   // ID instruction reads a nonzero register that the producer writes
   function automatic logic src_match(input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic u1,
                                      input logic [4:0] rs2, input logic u2);
      return (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
   endfunction

   // hazard need: load in EX feeding a branch costs two cycles, other
   // load hazards one; ALU producers are forwarded and never stall
   always_comb begin
      m_ex  = src_match(Rd_IDEX,  rs1_IFID, uses_rs1_IFID, rs2_IFID, uses_rs2_IFID);
      m_mem = src_match(Rd_EXMEM, rs1_IFID, uses_rs1_IFID, rs2_IFID, uses_rs2_IFID);
      need  = 2'd0;
      if (IDControlBranch && MemRead_IDEX && m_ex)        need = 2'd2;
      else if (MemRead_IDEX && m_ex)                      need = 2'd1;
      else if (IDControlBranch && MemRead_EXMEM && m_mem) need = 2'd1;
   end

   // priority: rst > dmem_busy > STALL > new hazard > flush > normal
   always_comb begin
      PCWrite     = 1'b1;
      IFIDWrite   = 1'b1;
      IDEX_bubble = 1'b0;
      IFID_flush  = 1'b0;
      pipe_freeze = 1'b0;
      state_d     = state_q;
      cnt_d       = cnt_q;
      stall_d     = stall_q;
      flush_d     = flush_q;
      if (rst) begin
         PCWrite     = 1'b0;
         IFIDWrite   = 1'b0;
         IDEX_bubble = 1'b1;
         IFID_flush  = 1'b1;
      end else if (dmem_busy) begin
         // whole pipe holds; state, cnt and counters are untouched
         pipe_freeze = 1'b1;
         PCWrite     = 1'b0;
         IFIDWrite   = 1'b0;
      end else if (state_q == STALL || need != 2'd0) begin
         PCWrite     = 1'b0;
         IFIDWrite   = 1'b0;
         IDEX_bubble = 1'b1;
         stall_d     = (stall_q == 16'hFFFF) ? stall_q : stall_q + 16'd1;
         if (state_q == STALL) begin
            // STALL masks detection until the remaining count drains
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) state_d = RUN;
         end else if (need == 2'd2) begin
            state_d = STALL;
            cnt_d   = 2'd1;
         end
      end else if ((IDControlBranch && branch_taken) || jump_ID) begin
         IFID_flush = 1'b1;
         flush_d    = (flush_q == 16'hFFFF) ? flush_q : flush_q + 16'd1;
      end
   end

   // state and counter registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         cnt_q   <= 2'd0;
         stall_q <= 16'd0;
         flush_q <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed + randomized bench for hazard_control_unit against a model that
// tracks "stall cycles still owed" as a plain integer.
module tb_hazard_control_unit;

   logic        clk, rst;
   logic [4:0]  rs1_IFID, rs2_IFID, Rd_IDEX, Rd_EXMEM;
   logic        uses_rs1_IFID, uses_rs2_IFID, IDControlBranch, branch_taken;
   logic        jump_ID, MemRead_IDEX, MemRead_EXMEM, dmem_busy;
   logic        PCWrite, IFIDWrite, IDEX_bubble, IFID_flush, pipe_freeze;
   logic [15:0] stall_cycles, flush_count;

   int checks = 0;
   int errors = 0;

   // model state
   int owed = 0;       // further forced stall cycles after the current one
   int m_stall = 0;
   int m_flush = 0;

   hazard_control_unit dut (
      .clk(clk), .rst(rst),
      .rs1_IFID(rs1_IFID), .rs2_IFID(rs2_IFID),
      .uses_rs1_IFID(uses_rs1_IFID), .uses_rs2_IFID(uses_rs2_IFID),
      .IDControlBranch(IDControlBranch), .branch_taken(branch_taken),
      .jump_ID(jump_ID),
      .Rd_IDEX(Rd_IDEX), .MemRead_IDEX(MemRead_IDEX),
      .Rd_EXMEM(Rd_EXMEM), .MemRead_EXMEM(MemRead_EXMEM),
      .dmem_busy(dmem_busy),
      .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEX_bubble(IDEX_bubble),
      .IFID_flush(IFID_flush), .pipe_freeze(pipe_freeze),
      .stall_cycles(stall_cycles), .flush_count(flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit reads(input logic [4:0] rd);
      if (rd == 0) return 0;
      return (uses_rs1_IFID && rs1_IFID == rd) || (uses_rs2_IFID && rs2_IFID == rd);
   endfunction

   // stall cycles the ID instruction needs, from the hazard rules
   function automatic int hazard_len();
      if (IDControlBranch && MemRead_IDEX && reads(Rd_IDEX)) return 2;
      if (MemRead_IDEX && reads(Rd_IDEX)) return 1;
      if (IDControlBranch && MemRead_EXMEM && reads(Rd_EXMEM)) return 1;
      return 0;
   endfunction

   task automatic clr();
      rst = 0; rs1_IFID = 0; rs2_IFID = 0; Rd_IDEX = 0; Rd_EXMEM = 0;
      uses_rs1_IFID = 0; uses_rs2_IFID = 0; IDControlBranch = 0;
      branch_taken = 0; jump_ID = 0; MemRead_IDEX = 0; MemRead_EXMEM = 0;
      dmem_busy = 0;
   endtask

   // one clock: inputs already applied; sample mid-cycle, then advance model
   task automatic cycle(input bit do_chk);
      bit e_pc, e_ifid, e_bub, e_fl, e_fr, is_stall, is_flush;
      int n;
      #2;
      n = hazard_len();
      is_stall = 0; is_flush = 0;
      e_pc = 1; e_ifid = 1; e_bub = 0; e_fl = 0; e_fr = 0;
      if (rst) begin
         e_pc = 0; e_ifid = 0; e_bub = 1; e_fl = 1;
      end else if (dmem_busy) begin
         e_fr = 1; e_pc = 0; e_ifid = 0;
      end else if (owed > 0 || n > 0) begin
         is_stall = 1; e_pc = 0; e_ifid = 0; e_bub = 1;
      end else if ((IDControlBranch && branch_taken) || jump_ID) begin
         is_flush = 1; e_fl = 1;
      end
      if (do_chk) begin
         chk("PCWrite", 32'(PCWrite), 32'(e_pc));
         chk("IFIDWrite", 32'(IFIDWrite), 32'(e_ifid));
         chk("IDEX_bubble", 32'(IDEX_bubble), 32'(e_bub));
         chk("IFID_flush", 32'(IFID_flush), 32'(e_fl));
         chk("pipe_freeze", 32'(pipe_freeze), 32'(e_fr));
         chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
         chk("flush_count", 32'(flush_count), 32'(m_flush));
      end
      @(posedge clk);
      if (rst) begin
         owed = 0; m_stall = 0; m_flush = 0;
      end else if (!dmem_busy) begin
         if (is_stall) begin
            m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
            owed = (owed > 0) ? owed - 1 : n - 1;
         end
         if (is_flush) m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
      end
      #1;
   endtask

   task automatic n2_hazard();
      clr();
      IDControlBranch = 1; branch_taken = 1; MemRead_IDEX = 1; Rd_IDEX = 7;
      rs2_IFID = 7; uses_rs2_IFID = 1;
   endtask

   initial begin
      clr();
      rst = 1;
      cycle(0);                      // counters unknown before first edge
      cycle(1);                      // reset outputs and cleared counters
      clr();
      cycle(1);                      // normal cycle

      // load-use, then same with rd = x0
      MemRead_IDEX = 1; Rd_IDEX = 5; rs1_IFID = 5; uses_rs1_IFID = 1;
      cycle(1);
      clr(); cycle(1);
      chk("loaduse_count", 32'(stall_cycles), 32'd1);
      MemRead_IDEX = 1; Rd_IDEX = 0; rs1_IFID = 0; uses_rs1_IFID = 1;
      cycle(1);

      // load in EX feeding taken branch: two stalls then one flush
      n2_hazard(); cycle(1);
      MemRead_IDEX = 0; MemRead_EXMEM = 1; Rd_EXMEM = 7; Rd_IDEX = 0;
      cycle(1);
      MemRead_EXMEM = 0; cycle(1);
      clr(); cycle(1);
      chk("n2_stall_count", 32'(stall_cycles), 32'd3);
      chk("n2_flush_count", 32'(flush_count), 32'd1);

      // taken branch, jump, ALU producer in EX
      IDControlBranch = 1; branch_taken = 1; cycle(1);
      clr(); jump_ID = 1; cycle(1);
      clr(); IDControlBranch = 1; Rd_IDEX = 9; rs1_IFID = 9; uses_rs1_IFID = 1;
      cycle(1);
      clr(); cycle(1);
      chk("flush_total", 32'(flush_count), 32'd3);

      // freeze during STALL
      rst = 1; cycle(1); clr();
      n2_hazard(); cycle(1);
      clr(); dmem_busy = 1;
      repeat (3) cycle(1);
      dmem_busy = 0; cycle(1);
      cycle(1);
      chk("freeze_stall_count", 32'(stall_cycles), 32'd2);

      // reset in second cycle of an N=2 stall
      n2_hazard(); cycle(1);
      clr(); rst = 1; cycle(1);
      rst = 0; cycle(1);
      chk("post_reset_count", 32'(stall_cycles), 32'd0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         rs1_IFID = 5'($urandom_range(0, 3));
         rs2_IFID = 5'($urandom_range(0, 3));
         Rd_IDEX = 5'($urandom_range(0, 3));
         Rd_EXMEM = 5'($urandom_range(0, 3));
         uses_rs1_IFID = 1'($urandom); uses_rs2_IFID = 1'($urandom);
         IDControlBranch = 1'($urandom); branch_taken = 1'($urandom);
         jump_ID = ($urandom_range(0, 5) == 0);
         MemRead_IDEX = 1'($urandom); MemRead_EXMEM = 1'($urandom);
         dmem_busy = ($urandom_range(0, 3) == 0);
         rst = ($urandom_range(0, 39) == 0);
         cycle(1);
      end

      // saturation of stall counter
      clr(); rst = 1; cycle(1); clr();
      MemRead_IDEX = 1; Rd_IDEX = 5; rs1_IFID = 5; uses_rs1_IFID = 1;
      repeat (70000) cycle(0);
      cycle(1);
      chk("stall_saturated", 32'(stall_cycles), 32'hFFFF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
